// File: rtl/ocr_segment_scheduler_pkg.sv
// Shared types and defaults for the OCR segment scheduler.
package ocr_segment_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_RESET_CU,
        S_LOAD,
        S_REPORT,
        S_DONE,
        S_ERROR
    } seg_sched_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_BP_RANGE = 2'd1,
        ERR_ORDER    = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } seg_err_t;

    localparam int unsigned CU_RST_CYCLES_DEF = 2;

endpackage

// File: rtl/ocr_segment_scheduler_if.sv
// Scheduler bus: controller start/abort/status, breakpoint RAM port and OCR core control.
// master = scheduler side, slave = controller / RAM / OCR core side.
interface ocr_segment_scheduler_if #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned BP_ADDR_W = 8,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned WD_W      = 16
);
    logic                 start;
    logic                 abort;
    logic [BP_ADDR_W-1:0] num_segments;
    logic [WD_W-1:0]      wd_limit;
    logic [BP_ADDR_W-1:0] bp_addr;
    logic [ADDR_W-1:0]    bp_data;
    logic                 bp_error;
    logic                 ocr_done;
    logic [7:0]           output_dig_detect;
    logic [ADDR_W-1:0]    addr_pixel_start;
    logic [ADDR_W-1:0]    addr_pixel_end;
    logic                 cu_rst;
    logic                 image_loaded;
    logic                 seg_valid;
    logic                 final_seg;
    logic                 busy;
    logic                 done;
    logic                 error_flag;
    logic [1:0]           err_code;
    logic [CNT_W-1:0]     seg_count;
    logic [CNT_W-1:0]     digit_seg_count;

    modport master (
        input  start, abort, num_segments, wd_limit, bp_data, bp_error,
               ocr_done, output_dig_detect,
        output bp_addr, addr_pixel_start, addr_pixel_end, cu_rst, image_loaded,
               seg_valid, final_seg, busy, done, error_flag, err_code,
               seg_count, digit_seg_count
    );

    modport slave (
        output start, abort, num_segments, wd_limit, bp_data, bp_error,
               ocr_done, output_dig_detect,
        input  bp_addr, addr_pixel_start, addr_pixel_end, cu_rst, image_loaded,
               seg_valid, final_seg, busy, done, error_flag, err_code,
               seg_count, digit_seg_count
    );

endinterface

// File: rtl/ocr_segment_scheduler_watchdog.sv
// Per-segment LOAD watchdog: counts enabled cycles from a clear; limit 0 never expires.
module ocr_segment_scheduler_watchdog #(
    parameter int unsigned WD_W = 16
) (
    input  logic            clk_in,
    input  logic            rst,
    input  logic            clear,
    input  logic            enable,
    input  logic [WD_W-1:0] limit,
    output logic            expired
);
    localparam logic [WD_W-1:0] WD_ONE = 1;

    logic [WD_W-1:0] count;

    // Cycle counter, held at all-ones rather than wrapping.
    always_ff @(posedge clk_in) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + WD_ONE;
        end
    end

    assign expired = enable && (limit != '0) && (count == (limit - WD_ONE));

endmodule

// File: rtl/ocr_segment_scheduler.sv
// Walks the breakpoint RAM, derives each segment's pixel window, launches the OCR core
// per segment under a watchdog and reports each result.
module ocr_segment_scheduler
    import ocr_segment_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned BP_ADDR_W     = 8,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned WD_W          = 16,
    parameter int unsigned CU_RST_CYCLES = CU_RST_CYCLES_DEF
) (
    input  logic                   clk_in,
    input  logic                   rst,
    ocr_segment_scheduler_if.master bus
);
    localparam int unsigned RC_W = (CU_RST_CYCLES > 1) ? $clog2(CU_RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]      RC_LAST  = RC_W'(CU_RST_CYCLES - 1);
    localparam logic [RC_W-1:0]      RC_ONE   = 1;
    localparam logic [BP_ADDR_W-1:0] BP_ONE   = 1;
    localparam logic [ADDR_W-1:0]    ADDR_ONE = 1;
    localparam logic [CNT_W-1:0]     CNT_ONE  = 1;

    seg_sched_state_t     state, state_next;
    seg_err_t             err_q, err_next;
    logic [BP_ADDR_W-1:0] idx, num_seg_q, bp_addr_q;
    logic [ADDR_W-1:0]    prev_end, start_addr, win_start, win_end;
    logic [CNT_W-1:0]     seg_cnt, dig_cnt;
    logic [RC_W-1:0]      rc_cnt;
    logic                 err_set, start_accept, load_window, do_report;
    logic                 enter_done, capture_dig, done_q, dig_nz;
    logic                 last_seg, in_load, wd_clear, wd_expired;

    assign in_load    = (state == S_LOAD);
    assign wd_clear   = !in_load;
    assign last_seg   = (idx == (num_seg_q - BP_ONE));
    assign start_addr = (idx == '0) ? '0 : (prev_end + ADDR_ONE);

    ocr_segment_scheduler_watchdog #(
        .WD_W (WD_W)
    ) u_watchdog (
        .clk_in  (clk_in),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (in_load),
        .limit   (bus.wd_limit),
        .expired (wd_expired)
    );

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control strobes; abort overrides everything.
    always_comb begin
        state_next   = state;
        err_next     = ERR_NONE;
        err_set      = 1'b0;
        start_accept = 1'b0;
        load_window  = 1'b0;
        do_report    = 1'b0;
        enter_done   = 1'b0;
        capture_dig  = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.start) begin
                    start_accept = 1'b1;
                    if (bus.num_segments == '0) begin
                        state_next = S_DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            S_FETCH: state_next = S_CHECK;
            S_CHECK: begin
                if (bus.bp_error) begin
                    state_next = S_ERROR;
                    err_next   = ERR_BP_RANGE;
                    err_set    = 1'b1;
                end else if (bus.bp_data < start_addr) begin
                    state_next = S_ERROR;
                    err_next   = ERR_ORDER;
                    err_set    = 1'b1;
                end else begin
                    load_window = 1'b1;
                    state_next  = S_RESET_CU;
                end
            end
            S_RESET_CU: begin
                if (rc_cnt == RC_LAST) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.ocr_done) begin
                    capture_dig = 1'b1;
                    state_next  = S_REPORT;
                end else if (wd_expired) begin
                    state_next = S_ERROR;
                    err_next   = ERR_TIMEOUT;
                    err_set    = 1'b1;
                end
            end
            S_REPORT: begin
                do_report = 1'b1;
                if (last_seg) begin
                    state_next = S_DONE;
                    enter_done = 1'b1;
                end else begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (bus.abort) begin
            state_next   = S_IDLE;
            err_set      = 1'b0;
            start_accept = 1'b0;
            load_window  = 1'b0;
            do_report    = 1'b0;
            enter_done   = 1'b0;
            capture_dig  = 1'b0;
        end
    end

    // Times the OCR core reset pulse; restarts from zero on every RESET_CU entry.
    always_ff @(posedge clk_in) begin
        if (rst || (state != S_RESET_CU)) begin
            rc_cnt <= '0;
        end else begin
            rc_cnt <= rc_cnt + RC_ONE;
        end
    end

    // Pass datapath: index, window, error code and saturating result counters.
    // The digit-detect flag is captured with ocr_done so REPORT does not depend
    // on the core holding its result an extra cycle.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            idx       <= '0;
            num_seg_q <= '0;
            bp_addr_q <= '0;
            prev_end  <= '0;
            win_start <= '0;
            win_end   <= '0;
            seg_cnt   <= '0;
            dig_cnt   <= '0;
            err_q     <= ERR_NONE;
            done_q    <= 1'b0;
            dig_nz    <= 1'b0;
        end else begin
            done_q <= enter_done;
            if (bus.abort || start_accept) begin
                err_q <= ERR_NONE;
            end else if (err_set) begin
                err_q <= err_next;
            end
            if (start_accept) begin
                idx       <= '0;
                prev_end  <= '0;
                seg_cnt   <= '0;
                dig_cnt   <= '0;
                num_seg_q <= bus.num_segments;
                if (bus.num_segments != '0) begin
                    bp_addr_q <= '0;
                end
            end
            if (load_window) begin
                win_start <= start_addr;
                win_end   <= bus.bp_data;
                prev_end  <= bus.bp_data;
            end
            if (capture_dig) begin
                dig_nz <= |bus.output_dig_detect;
            end
            if (do_report) begin
                if (seg_cnt != '1) begin
                    seg_cnt <= seg_cnt + CNT_ONE;
                end
                if (dig_nz && (dig_cnt != '1)) begin
                    dig_cnt <= dig_cnt + CNT_ONE;
                end
                if (!last_seg) begin
                    idx       <= idx + BP_ONE;
                    bp_addr_q <= idx + BP_ONE;
                end
            end
        end
    end

    assign bus.bp_addr          = bp_addr_q;
    assign bus.addr_pixel_start = win_start;
    assign bus.addr_pixel_end   = win_end;
    assign bus.cu_rst           = !((state == S_LOAD) || (state == S_REPORT));
    assign bus.image_loaded     = in_load;
    assign bus.seg_valid        = (state == S_REPORT);
    assign bus.final_seg        = (state == S_REPORT) && last_seg;
    assign bus.busy             = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign bus.done             = done_q;
    assign bus.error_flag       = (state == S_ERROR);
    assign bus.err_code         = err_q;
    assign bus.seg_count        = seg_cnt;
    assign bus.digit_seg_count  = dig_cnt;

endmodule

// File: tb/tb_ocr_segment_scheduler.sv
// Directed bench for the OCR segment scheduler: table-driven passes plus corner sequences.
module tb_ocr_segment_scheduler;

    typedef struct {
        int          seg;
        logic [15:0] bp;
        logic [7:0]  dig;
        int          delay;
        logic [15:0] exp_s;
        logic [15:0] exp_e;
        bit          exp_final;
        int          exp_dcnt;
    } seg_vec_t;

    logic clk_in = 1'b0;
    logic rst;
    always #5 clk_in = ~clk_in;

    ocr_segment_scheduler_if #(.ADDR_W(16), .BP_ADDR_W(8), .CNT_W(8), .WD_W(16)) bus ();

    ocr_segment_scheduler #(
        .ADDR_W        (16),
        .BP_ADDR_W     (8),
        .CNT_W         (8),
        .WD_W          (16),
        .CU_RST_CYCLES (2)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    logic [15:0] bp_mem [256];
    int          bp_err_idx;
    assign bus.bp_data  = bp_mem[bus.bp_addr];
    assign bus.bp_error = (bp_err_idx >= 0) && (int'(bus.bp_addr) == bp_err_idx);

    int n_pass  = 0;
    int n_total = 0;
    int sv_cnt  = 0;
    int dn_cnt  = 0;

    always @(posedge clk_in) begin
        if (bus.seg_valid) sv_cnt = sv_cnt + 1;
        if (bus.done) dn_cnt = dn_cnt + 1;
    end

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic pulse_start(input int n);
        bus.num_segments = 8'(n);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_load(output int cyc);
        cyc = 0;
        while (!bus.image_loaded && cyc < 60) begin
            tick();
            cyc++;
        end
        chk("image_loaded_wait", 32'(bus.image_loaded), 32'd1);
    endtask

    // Entered at the negedge of FETCH; returns at the negedge after REPORT.
    task automatic run_segment(input int seg, input int delay, input logic [7:0] dig,
                               input logic [15:0] es, input logic [15:0] ee, input bit efinal,
                               input int scnt, input int dcnt);
        int cyc;
        wait_load(cyc);
        chk($sformatf("s%0d_latency", seg), 32'(cyc), 32'd4);
        chk($sformatf("s%0d_win_start", seg), 32'(bus.addr_pixel_start), 32'(es));
        chk($sformatf("s%0d_win_end", seg), 32'(bus.addr_pixel_end), 32'(ee));
        chk($sformatf("s%0d_cu_rst_load", seg), 32'(bus.cu_rst), 32'd0);
        repeat (delay) tick();
        bus.ocr_done = 1'b1;
        bus.output_dig_detect = dig;
        tick();
        bus.ocr_done = 1'b0;
        chk($sformatf("s%0d_seg_valid", seg), 32'(bus.seg_valid), 32'd1);
        chk($sformatf("s%0d_final_seg", seg), 32'(bus.final_seg), 32'(efinal));
        chk($sformatf("s%0d_loaded_report", seg), 32'(bus.image_loaded), 32'd0);
        tick();
        bus.output_dig_detect = '0;
        chk($sformatf("s%0d_seg_count", seg), 32'(bus.seg_count), 32'(scnt));
        chk($sformatf("s%0d_digit_count", seg), 32'(bus.digit_seg_count), 32'(dcnt));
        chk($sformatf("s%0d_valid_gone", seg), 32'(bus.seg_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "simulation time limit");
    end

    initial begin
        seg_vec_t vt [7];
        int n, sv_base, dn_base, cyc;

        // pass A: bp {9,19,29}, ocr_done 5 cycles into LOAD
        vt[0] = '{0, 16'd9,     8'd0, 5, 16'd0,   16'd9,     1'b0, 0};
        vt[1] = '{1, 16'd19,    8'd0, 5, 16'd10,  16'd19,    1'b0, 0};
        vt[2] = '{2, 16'd29,    8'd0, 5, 16'd20,  16'd29,    1'b1, 0};
        // pass B: dig {0,2,0,7}, mixed latencies, last window reaches the top address
        vt[3] = '{0, 16'd3,     8'd0, 0, 16'd0,   16'd3,     1'b0, 0};
        vt[4] = '{1, 16'd7,     8'd2, 1, 16'd4,   16'd7,     1'b0, 1};
        vt[5] = '{2, 16'd100,   8'd0, 2, 16'd8,   16'd100,   1'b0, 1};
        vt[6] = '{3, 16'd65535, 8'd7, 0, 16'd101, 16'd65535, 1'b1, 2};

        for (int i = 0; i < 256; i++) bp_mem[i] = '0;
        bp_err_idx = -1;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.num_segments = '0;
        bus.wd_limit = '0;
        bus.ocr_done = 1'b0;
        bus.output_dig_detect = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_cu_rst", 32'(bus.cu_rst), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_image_loaded", 32'(bus.image_loaded), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_error_flag", 32'(bus.error_flag), 32'd0);
        chk("rst_err_code", 32'(bus.err_code), 32'd0);
        chk("rst_bp_addr", 32'(bus.bp_addr), 32'd0);
        chk("rst_seg_count", 32'(bus.seg_count), 32'd0);

        // table-driven passes
        n = 0;
        sv_base = 0;
        dn_base = 0;
        for (int i = 0; i < 7; i++) begin
            if (vt[i].seg == 0) begin
                n = 0;
                for (int j = i; j < 7; j++) begin
                    if (j > i && vt[j].seg == 0) break;
                    bp_mem[vt[j].seg] = vt[j].bp;
                    n++;
                end
                sv_base = sv_cnt;
                dn_base = dn_cnt;
                pulse_start(n);
                chk("pass_busy", 32'(bus.busy), 32'd1);
                chk("pass_bp_addr0", 32'(bus.bp_addr), 32'd0);
            end
            run_segment(vt[i].seg, vt[i].delay, vt[i].dig, vt[i].exp_s, vt[i].exp_e,
                        vt[i].exp_final, vt[i].seg + 1, vt[i].exp_dcnt);
            if (vt[i].exp_final) begin
                chk("pass_done", 32'(bus.done), 32'd1);
                chk("pass_busy_done", 32'(bus.busy), 32'd0);
                chk("pass_cu_rst_done", 32'(bus.cu_rst), 32'd1);
                tick();
                chk("pass_done_pulse", 32'(bus.done), 32'd0);
                chk("pass_valid_pulses", 32'(sv_cnt - sv_base), 32'(n));
                chk("pass_done_pulses", 32'(dn_cnt - dn_base), 32'd1);
            end
        end

        // breakpoint order violation on the second segment
        bp_mem[0] = 16'd9;
        bp_mem[1] = 16'd5;
        pulse_start(2);
        run_segment(0, 1, 8'd0, 16'd0, 16'd9, 1'b0, 1, 0);
        tick();
        tick();
        chk("order_error_flag", 32'(bus.error_flag), 32'd1);
        chk("order_err_code", 32'(bus.err_code), 32'd2);
        chk("order_seg_count", 32'(bus.seg_count), 32'd1);
        chk("order_cu_rst", 32'(bus.cu_rst), 32'd1);
        chk("order_busy", 32'(bus.busy), 32'd0);
        chk("order_win_end_held", 32'(bus.addr_pixel_end), 32'd9);
        tick();
        chk("order_err_sticky", 32'(bus.err_code), 32'd2);

        // empty pass straight from ERROR: done next cycle, no RAM or core activity
        dn_base = dn_cnt;
        pulse_start(0);
        chk("empty_done", 32'(bus.done), 32'd1);
        chk("empty_err_cleared", 32'(bus.err_code), 32'd0);
        chk("empty_error_flag", 32'(bus.error_flag), 32'd0);
        chk("empty_cu_rst", 32'(bus.cu_rst), 32'd1);
        chk("empty_bp_addr_held", 32'(bus.bp_addr), 32'd1);
        tick();
        chk("empty_done_pulse", 32'(bus.done), 32'd0);
        chk("empty_done_pulses", 32'(dn_cnt - dn_base), 32'd1);

        // breakpoint RAM range error
        bp_err_idx = 0;
        pulse_start(1);
        tick();
        tick();
        chk("range_error_flag", 32'(bus.error_flag), 32'd1);
        chk("range_err_code", 32'(bus.err_code), 32'd1);
        bp_err_idx = -1;

        // watchdog expiry after exactly four LOAD cycles
        bus.wd_limit = 16'd4;
        pulse_start(1);
        wait_load(cyc);
        repeat (3) tick();
        chk("wd_still_loaded", 32'(bus.image_loaded), 32'd1);
        chk("wd_no_error_yet", 32'(bus.error_flag), 32'd0);
        tick();
        chk("wd_error_flag", 32'(bus.error_flag), 32'd1);
        chk("wd_err_code", 32'(bus.err_code), 32'd3);
        chk("wd_image_loaded", 32'(bus.image_loaded), 32'd0);

        // ocr_done in the expiry cycle beats the timeout
        bus.wd_limit = 16'd2;
        pulse_start(1);
        wait_load(cyc);
        tick();
        bus.ocr_done = 1'b1;
        tick();
        bus.ocr_done = 1'b0;
        chk("wd_tie_seg_valid", 32'(bus.seg_valid), 32'd1);
        chk("wd_tie_error_flag", 32'(bus.error_flag), 32'd0);
        tick();
        chk("wd_tie_done", 32'(bus.done), 32'd1);

        // watchdog disabled
        bus.wd_limit = 16'd0;
        pulse_start(1);
        wait_load(cyc);
        repeat (200) tick();
        chk("wd_off_loaded", 32'(bus.image_loaded), 32'd1);
        chk("wd_off_busy", 32'(bus.busy), 32'd1);
        bus.ocr_done = 1'b1;
        tick();
        bus.ocr_done = 1'b0;
        chk("wd_off_seg_valid", 32'(bus.seg_valid), 32'd1);
        tick();
        chk("wd_off_done", 32'(bus.done), 32'd1);

        // abort during LOAD of the second segment, then restart
        bp_mem[0] = 16'd9;
        bp_mem[1] = 16'd19;
        bp_mem[2] = 16'd29;
        sv_base = sv_cnt;
        pulse_start(3);
        run_segment(0, 0, 8'd3, 16'd0, 16'd9, 1'b0, 1, 1);
        wait_load(cyc);
        chk("abort_s1_latency", 32'(cyc), 32'd4);
        repeat (2) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_image_loaded", 32'(bus.image_loaded), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_cu_rst", 32'(bus.cu_rst), 32'd1);
        chk("abort_seg_valid", 32'(bus.seg_valid), 32'd0);
        chk("abort_err_code", 32'(bus.err_code), 32'd0);
        chk("abort_seg_count_held", 32'(bus.seg_count), 32'd1);
        chk("abort_digit_count_held", 32'(bus.digit_seg_count), 32'd1);
        chk("abort_bp_addr_held", 32'(bus.bp_addr), 32'd1);
        bus.ocr_done = 1'b1;
        tick();
        bus.ocr_done = 1'b0;
        chk("idle_ocr_done_ignored", 32'(bus.seg_valid), 32'd0);
        tick();
        chk("abort_valid_pulses", 32'(sv_cnt - sv_base), 32'd1);
        pulse_start(1);
        chk("restart_bp_addr", 32'(bus.bp_addr), 32'd0);
        chk("restart_busy", 32'(bus.busy), 32'd1);
        run_segment(0, 2, 8'd0, 16'd0, 16'd9, 1'b1, 1, 0);
        chk("restart_done", 32'(bus.done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
